// File: rtl/fpu_csr_queue_pkg.sv
// Shared definitions for the FPU command/result queue front end.
// Holds the bus register map, STATUS/CTRL bit positions and the result entry
// record that travels through the result FIFO.
package fpu_csr_queue_pkg;

  // Register map
  localparam int unsigned AddrAReg   = 0;
  localparam int unsigned AddrBReg   = 1;
  localparam int unsigned AddrCmd    = 2;
  localparam int unsigned AddrResult = 3;
  localparam int unsigned AddrStatus = 4;
  localparam int unsigned AddrCtrl   = 5;

  // STATUS layout
  localparam int unsigned StCmdCountLsb = 0;
  localparam int unsigned StResCountLsb = 8;
  localparam int unsigned StInFlightLsb = 16;
  localparam int unsigned StCountW      = 5;
  localparam int unsigned StExcBit      = 24;
  localparam int unsigned StOvfBit      = 25;
  localparam int unsigned StUnfBit      = 26;
  localparam int unsigned StCmdOvfBit   = 28;
  localparam int unsigned StResUdfBit   = 29;
  localparam int unsigned StBusyBit     = 31;

  // CTRL layout
  localparam int unsigned CtrlIrqEnBit = 0;
  localparam int unsigned CtrlClrBit   = 1;
  localparam int unsigned CtrlFlushBit = 2;

  // Result entry: 32-bit result plus exception flags
  typedef struct packed {
    logic [31:0] result;
    logic        exc;
    logic        ovf;
    logic        unf;
  } res_entry_t;

  localparam int unsigned ResEntryW = $bits(res_entry_t);

endpackage

// File: rtl/fpu_sync_fifo.sv
// Synchronous FIFO with synchronous active-high reset and a flush input.
// Ports: clk, rst, flush (empties the FIFO), push/wdata, pop/rdata (head,
// combinational), count (0..DEPTH), full, empty. Push when full and pop when
// empty are ignored.
module fpu_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CntFull = DEPTH[PtrW:0];
  localparam logic [PtrW:0] CntOne  = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntFull);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Power-of-two depth: pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntOne;
      else if (!do_push && do_pop) count_q <= count_q - CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fpu_csr_queue.sv
// Bus-facing command/result queue in front of an FPU core.
// Ports: Clk, Rst (sync, active-high); bus ChipSelect/Write/Read/Address/
// WriteData/ReadData (registered); Irq (registered level); core issue
// core_valid/core_a/core_b/core_op; core completion core_done/core_result/
// core_exc/core_ovf/core_unf.
module fpu_csr_queue
  import fpu_csr_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              ChipSelect,
  input  logic              Write,
  input  logic              Read,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              Irq,
  output logic              core_valid,
  output logic [31:0]       core_a,
  output logic [31:0]       core_b,
  output logic [OP_W-1:0]   core_op,
  input  logic              core_done,
  input  logic [31:0]       core_result,
  input  logic              core_exc,
  input  logic              core_ovf,
  input  logic              core_unf
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned CmdW = 64 + OP_W;
  localparam logic [CntW:0]   CreditMax = DEPTH[CntW:0];
  localparam logic [CntW-1:0] CntOne    = 1;

  logic [31:0]     a_q, b_q, rdata_q, rd_value, status;
  logic [CntW-1:0] in_flight_q, in_flight_d, cmd_count, res_count, res_cnt_d;
  logic            irq_en_q, irq_en_d, irq_q, irq_d;
  logic            exc_q, ovf_q, unf_q, cmd_ovf_q, res_udf_q;
  logic            exc_d, ovf_d, unf_d, cmd_ovf_d, res_udf_d;
  logic            wr, rd, wr_cmd, wr_ctrl, rd_result, ctrl_flush;
  logic            issue, done_ok, res_push, res_pop;
  logic            cmd_full, cmd_empty, res_full, res_empty;
  logic [CmdW-1:0] cmd_rdata;
  logic [CntW:0]   credit_sum;
  res_entry_t      res_head, res_wdata;

  assign wr         = ChipSelect & Write;
  assign rd         = ChipSelect & Read;
  assign wr_cmd     = wr & (Address == ADDR_W'(AddrCmd));
  assign wr_ctrl    = wr & (Address == ADDR_W'(AddrCtrl));
  assign rd_result  = rd & (Address == ADDR_W'(AddrResult));
  assign ctrl_flush = wr_ctrl & WriteData[CtrlFlushBit];

  // Credit: every issued op must have a guaranteed result slot.
  assign credit_sum = {1'b0, in_flight_q} + {1'b0, res_count};
  assign issue      = ~cmd_empty & (credit_sum < CreditMax) & ~Rst;
  assign core_valid = issue;
  assign {core_a, core_b, core_op} = cmd_rdata;

  // Completions with nothing outstanding are stale (e.g. after reset).
  assign done_ok = core_done & (in_flight_q != '0);
  // Push and underflowing pop together at count 0 leave the FIFO empty.
  assign res_pop   = rd_result & ~res_empty;
  assign res_push  = done_ok & ~(rd_result & res_empty);
  assign res_wdata = '{result: core_result, exc: core_exc, ovf: core_ovf, unf: core_unf};

  fpu_sync_fifo #(.WIDTH(CmdW), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .flush (ctrl_flush),
    .push  (wr_cmd),
    .wdata ({a_q, b_q, WriteData[OP_W-1:0]}),
    .pop   (issue),
    .rdata (cmd_rdata),
    .count (cmd_count),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  fpu_sync_fifo #(.WIDTH(ResEntryW), .DEPTH(DEPTH)) u_res_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .flush (1'b0),
    .push  (res_push),
    .wdata (res_wdata),
    .pop   (res_pop),
    .rdata (res_head),
    .count (res_count),
    .full  (res_full),
    .empty (res_empty)
  );

  always_comb begin
    status = '0;
    status[StCmdCountLsb +: StCountW] = StCountW'(cmd_count);
    status[StResCountLsb +: StCountW] = StCountW'(res_count);
    status[StInFlightLsb +: StCountW] = StCountW'(in_flight_q);
    status[StExcBit]    = exc_q;
    status[StOvfBit]    = ovf_q;
    status[StUnfBit]    = unf_q;
    status[StCmdOvfBit] = cmd_ovf_q;
    status[StResUdfBit] = res_udf_q;
    status[StBusyBit]   = (cmd_count != '0) | (in_flight_q != '0);
  end

  always_comb begin
    rd_value = '0;
    if (Address == ADDR_W'(AddrAReg))        rd_value = a_q;
    else if (Address == ADDR_W'(AddrBReg))   rd_value = b_q;
    else if (Address == ADDR_W'(AddrResult)) rd_value = res_empty ? '0 : res_head.result;
    else if (Address == ADDR_W'(AddrStatus)) rd_value = status;
    else if (Address == ADDR_W'(AddrCtrl))   rd_value = {31'b0, irq_en_q};
  end

  always_comb begin
    in_flight_d = in_flight_q;
    if (issue && !done_ok)      in_flight_d = in_flight_q + CntOne;
    else if (!issue && done_ok) in_flight_d = in_flight_q - CntOne;
    res_cnt_d = res_count;
    if (res_push && !res_pop)      res_cnt_d = res_count + CntOne;
    else if (!res_push && res_pop) res_cnt_d = res_count - CntOne;

    irq_en_d  = wr_ctrl ? WriteData[CtrlIrqEnBit] : irq_en_q;
    exc_d     = exc_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    cmd_ovf_d = cmd_ovf_q;
    res_udf_d = res_udf_q;
    if (wr_ctrl && WriteData[CtrlClrBit]) begin
      {exc_d, ovf_d, unf_d, cmd_ovf_d, res_udf_d} = '0;
    end
    // Core flags become visible only once their entry is read out.
    if (res_pop) begin
      exc_d = exc_d | res_head.exc;
      ovf_d = ovf_d | res_head.ovf;
      unf_d = unf_d | res_head.unf;
    end
    if (wr_cmd && cmd_full)     cmd_ovf_d = 1'b1;
    if (rd_result && res_empty) res_udf_d = 1'b1;

    // Built from next-state so Irq tracks the registers it summarises.
    irq_d = irq_en_d & ((res_cnt_d != '0) | exc_d | ovf_d | unf_d | cmd_ovf_d | res_udf_d);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      a_q         <= '0;
      b_q         <= '0;
      rdata_q     <= '0;
      in_flight_q <= '0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
      exc_q       <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      cmd_ovf_q   <= 1'b0;
      res_udf_q   <= 1'b0;
    end else begin
      if (wr && Address == ADDR_W'(AddrAReg)) a_q <= WriteData;
      if (wr && Address == ADDR_W'(AddrBReg)) b_q <= WriteData;
      if (rd) rdata_q <= rd_value;
      in_flight_q <= in_flight_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
      exc_q       <= exc_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      cmd_ovf_q   <= cmd_ovf_d;
      res_udf_q   <= res_udf_d;
    end
  end

  assign ReadData = rdata_q;
  assign Irq      = irq_q;

endmodule

// File: tb/tb_fpu_csr_queue.sv
// Self-checking bench for fpu_csr_queue: register table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_fpu_csr_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned ADDR_W = 3;

  logic              Clk;
  logic              Rst, ChipSelect, Write, Read;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       WriteData, ReadData;
  logic              Irq, core_valid;
  logic [31:0]       core_a, core_b;
  logic [OP_W-1:0]   core_op;
  logic              core_done;
  logic [31:0]       core_result;
  logic              core_exc, core_ovf, core_unf;

  fpu_csr_queue #(.DEPTH(DEPTH), .OP_W(OP_W), .ADDR_W(ADDR_W)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .ChipSelect  (ChipSelect),
    .Write       (Write),
    .Read        (Read),
    .Address     (Address),
    .WriteData   (WriteData),
    .ReadData    (ReadData),
    .Irq         (Irq),
    .core_valid  (core_valid),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_op     (core_op),
    .core_done   (core_done),
    .core_result (core_result),
    .core_exc    (core_exc),
    .core_ovf    (core_ovf),
    .core_unf    (core_unf)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {logic [31:0] a; logic [31:0] b; logic [OP_W-1:0] op;} cmd_t;
  typedef struct packed {logic [31:0] r; logic e; logic o; logic u;} res_t;

  // Reference model state
  cmd_t        m_cmdq[$];
  res_t        m_resq[$];
  logic [31:0] m_a, m_b, m_rdata;
  int          m_inflight;
  bit          m_irq_en, m_irq, m_exc, m_ovf, m_unf, m_cmd_ovf, m_res_udf;

  int n_tests = 0;
  int n_fail  = 0;
  int n_issue = 0;
  int core_pending = 0;
  bit last_valid;
  logic [31:0] last_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[4:0]   = 5'(m_cmdq.size());
    s[12:8]  = 5'(m_resq.size());
    s[20:16] = 5'(m_inflight);
    s[24] = m_exc;
    s[25] = m_ovf;
    s[26] = m_unf;
    s[28] = m_cmd_ovf;
    s[29] = m_res_udf;
    s[31] = (m_cmdq.size() != 0) || (m_inflight != 0);
    return s;
  endfunction

  // One bus cycle: drive, check issue outputs before the edge, update model, check after.
  task automatic cycle(input bit rst, input bit cs, input bit wr, input bit rd,
                       input logic [2:0] addr, input logic [31:0] wd, input bit dn,
                       input logic [31:0] res, input logic [2:0] fl);
    bit issue, pre_empty, done_ok, we, re;
    int pre_cmd;
    logic [31:0] st;
    cmd_t c;
    res_t r;
    Rst = rst; ChipSelect = cs; Write = wr; Read = rd; Address = addr; WriteData = wd;
    core_done = dn; core_result = res; {core_exc, core_ovf, core_unf} = fl;
    #2;
    issue = !rst && (m_cmdq.size() > 0) && (m_inflight + m_resq.size() < int'(DEPTH));
    last_valid = core_valid;
    last_a = core_a;
    check("core_valid", {31'b0, core_valid}, {31'b0, issue});
    if (issue) begin
      c = m_cmdq[0];
      check("core_a", core_a, c.a);
      check("core_b", core_b, c.b);
      check("core_op", 32'(core_op), 32'(c.op));
      n_issue++;
      core_pending++;
    end
    @(posedge Clk);
    #1;
    if (rst) begin
      m_cmdq.delete(); m_resq.delete();
      m_a = 0; m_b = 0; m_rdata = 0; m_inflight = 0;
      {m_irq_en, m_irq, m_exc, m_ovf, m_unf, m_cmd_ovf, m_res_udf} = '0;
    end else begin
      we = cs && wr;
      re = cs && rd;
      st = m_status();
      pre_cmd = m_cmdq.size();
      pre_empty = (m_resq.size() == 0);
      done_ok = dn && (m_inflight > 0);
      if (re) begin
        case (addr)
          3'd0: m_rdata = m_a;
          3'd1: m_rdata = m_b;
          3'd3: begin
            if (!pre_empty) begin
              r = m_resq.pop_front();
              m_rdata = r.r;
              m_exc |= r.e; m_ovf |= r.o; m_unf |= r.u;
            end else begin
              m_rdata = 0;
              m_res_udf = 1;
            end
          end
          3'd4: m_rdata = st;
          3'd5: m_rdata = {31'b0, m_irq_en};
          default: m_rdata = 0;
        endcase
      end
      if (issue) void'(m_cmdq.pop_front());
      if (we) begin
        case (addr)
          3'd0: m_a = wd;
          3'd1: m_b = wd;
          3'd2: if (pre_cmd == int'(DEPTH)) m_cmd_ovf = 1;
                else m_cmdq.push_back({m_a, m_b, wd[OP_W-1:0]});
          3'd5: begin
            m_irq_en = wd[0];
            if (wd[1]) {m_exc, m_ovf, m_unf, m_cmd_ovf, m_res_udf} = '0;
            if (wd[2]) m_cmdq.delete();
          end
          default: ;
        endcase
      end
      m_inflight = m_inflight + (issue ? 1 : 0) - (done_ok ? 1 : 0);
      if (done_ok && !(re && addr == 3'd3 && pre_empty)) m_resq.push_back({res, fl});
      m_irq = m_irq_en && ((m_resq.size() != 0) || m_exc || m_ovf || m_unf
                           || m_cmd_ovf || m_res_udf);
    end
    check("ReadData", ReadData, m_rdata);
    check("Irq", {31'b0, Irq}, {31'b0, m_irq});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 3'd0, 32'h0, 0, 32'h0, 3'b0);
  endtask
  task automatic bwr(input logic [2:0] addr, input logic [31:0] wd);
    cycle(0, 1, 1, 0, addr, wd, 0, 32'h0, 3'b0);
  endtask
  task automatic brd(input logic [2:0] addr);
    cycle(0, 1, 0, 1, addr, 32'h0, 0, 32'h0, 3'b0);
  endtask
  task automatic reset_cycle();
    cycle(1, 0, 0, 0, 3'd0, 32'h0, 0, 32'h0, 3'b0);
  endtask

  typedef struct {
    bit wr; bit rd; logic [2:0] addr; logic [31:0] wd; bit chk; logic [31:0] exp;
  } vec_t;
  localparam int NV = 13;
  vec_t vecs[NV];

  initial begin
    int iss0;
    Rst = 1; ChipSelect = 0; Write = 0; Read = 0; Address = 0; WriteData = 0;
    core_done = 0; core_result = 0; core_exc = 0; core_ovf = 0; core_unf = 0;

    // Reset state
    reset_cycle();
    brd(3'd4);
    check("reset_status", ReadData, 32'h0);
    check("reset_irq", {31'b0, Irq}, 32'h0);

    // Register table
    vecs[0]  = '{1, 0, 3'd0, 32'h12345678, 0, 32'h0};
    vecs[1]  = '{0, 1, 3'd0, 32'h0, 1, 32'h12345678};
    vecs[2]  = '{1, 0, 3'd1, 32'hCAFEF00D, 0, 32'h0};
    vecs[3]  = '{0, 1, 3'd1, 32'h0, 1, 32'hCAFEF00D};
    vecs[4]  = '{1, 0, 3'd6, 32'hFFFFFFFF, 0, 32'h0};
    vecs[5]  = '{0, 1, 3'd6, 32'h0, 1, 32'h0};
    vecs[6]  = '{0, 1, 3'd7, 32'h0, 1, 32'h0};
    vecs[7]  = '{0, 1, 3'd2, 32'h0, 1, 32'h0};
    vecs[8]  = '{1, 0, 3'd5, 32'h7, 0, 32'h0};
    vecs[9]  = '{0, 1, 3'd5, 32'h0, 1, 32'h1};
    vecs[10] = '{0, 1, 3'd4, 32'h0, 1, 32'h0};
    vecs[11] = '{1, 0, 3'd5, 32'h0, 0, 32'h0};
    vecs[12] = '{0, 1, 3'd5, 32'h0, 1, 32'h0};
    for (int i = 0; i < NV; i++) begin
      cycle(0, 1, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wd, 0, 32'h0, 3'b0);
      if (vecs[i].chk) check("vec_rdata", ReadData, vecs[i].exp);
    end

    // Single operation round trip
    reset_cycle();
    bwr(3'd0, 32'h3F800000);
    bwr(3'd1, 32'h40000000);
    bwr(3'd2, 32'h0);
    idle(1);
    check("rt_issue", {31'b0, last_valid}, 32'h1);
    check("rt_core_a", last_a, 32'h3F800000);
    idle(2);
    cycle(0, 0, 0, 0, 3'd0, 32'h0, 1, 32'h40400000, 3'b0);
    brd(3'd4);
    check("rt_status_cnt", ReadData, 32'h00000100);
    brd(3'd3);
    check("rt_result", ReadData, 32'h40400000);
    brd(3'd4);
    check("rt_status_empty", ReadData, 32'h0);

    // Command overflow with the core stalled
    reset_cycle();
    iss0 = n_issue;
    for (int i = 0; i < 2 * DEPTH + 1; i++) bwr(3'd2, 32'(i));
    idle(1);
    check("ovf_issued", 32'(n_issue - iss0), 32'(DEPTH));
    brd(3'd4);
    check("ovf_status", ReadData, 32'(DEPTH) | (32'(DEPTH) << 16) | 32'h90000000);

    // Underflow and sticky clear
    reset_cycle();
    bwr(3'd5, 32'h1);
    brd(3'd3);
    check("udf_rdata", ReadData, 32'h0);
    check("udf_irq", {31'b0, Irq}, 32'h1);
    brd(3'd4);
    check("udf_status", ReadData, 32'h20000000);
    bwr(3'd5, 32'h3);
    check("clr_irq", {31'b0, Irq}, 32'h0);

    // Push and pop together; flags surface only on pop
    bwr(3'd0, 32'h1);
    bwr(3'd1, 32'h2);
    bwr(3'd2, 32'h1);
    idle(1);
    cycle(0, 0, 0, 0, 3'd0, 32'h0, 1, 32'h11111111, 3'b000);
    bwr(3'd2, 32'h2);
    idle(1);
    cycle(0, 1, 0, 1, 3'd3, 32'h0, 1, 32'h22222222, 3'b010);
    check("pp_rdata", ReadData, 32'h11111111);
    brd(3'd4);
    check("pp_status", ReadData, 32'h00000100);
    brd(3'd3);
    check("pp_result2", ReadData, 32'h22222222);
    brd(3'd4);
    check("pp_ovf_sticky", ReadData, 32'h02000000);

    // Push with underflowing pop at count 0
    reset_cycle();
    bwr(3'd2, 32'h3);
    idle(1);
    cycle(0, 1, 0, 1, 3'd3, 32'h0, 1, 32'h33333333, 3'b0);
    check("z_rdata", ReadData, 32'h0);
    brd(3'd4);
    check("z_status", ReadData, 32'h20000000);

    // Reset with work in flight; stale completions ignored
    reset_cycle();
    bwr(3'd2, 32'h4);
    bwr(3'd2, 32'h5);
    idle(2);
    brd(3'd4);
    check("rst_pre_status", ReadData, 32'h80020000);
    reset_cycle();
    iss0 = n_issue;
    cycle(0, 0, 0, 0, 3'd0, 32'h0, 1, 32'h44444444, 3'b111);
    cycle(0, 0, 0, 0, 3'd0, 32'h0, 1, 32'h55555555, 3'b111);
    brd(3'd4);
    check("rst_post_status", ReadData, 32'h0);
    check("rst_no_issue", 32'(n_issue - iss0), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit rs, cs, wr, rd, dn;
      logic [2:0] ad, fl;
      logic [31:0] wd;
      r = $urandom_range(0, 99);
      rs = 0; cs = 1; wr = 0; rd = 0; dn = 0; ad = 3'd0; wd = $urandom;
      if (r < 1) rs = 1;
      else if (r < 11) begin wr = 1; ad = 3'($urandom_range(0, 1)); end
      else if (r < 36) begin wr = 1; ad = 3'd2; end
      else if (r < 56) begin rd = 1; ad = 3'd3; end
      else if (r < 71) begin rd = 1; ad = 3'd4; end
      else if (r < 76) begin
        wr = 1; ad = 3'd5;
        wd = {29'b0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
              1'($urandom_range(0, 1))};
      end
      else if (r < 86) begin rd = 1; ad = 3'($urandom_range(0, 7)); end
      else if (r < 90) begin wr = 1; ad = 3'($urandom_range(6, 7)); end
      if ($urandom_range(0, 19) == 0) cs = 0;
      if (core_pending > 0 && $urandom_range(0, 2) == 0) begin
        dn = 1;
        core_pending--;
      end
      fl = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b0;
      cycle(rs, cs, wr, rd, ad, wd, dn, $urandom, fl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
